// File: rtl/one_to_two_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : one_to_two_pkg
//  Description : Shared constants for the one_to_two width up-converter.
//                Holds the default word width and the encoding of the
//                converter occupancy state {dout_valid, lo_valid}.
//  Revision    : 1.0 - initial release
// ============================================================================
package one_to_two_pkg;

    // Default width of one input word.
    localparam int unsigned DEFAULT_WORD_LEN = 33;

    // Occupancy state, encoded as {dout_valid, lo_valid}.
    localparam logic [1:0] ST_EMPTY    = 2'b00;
    localparam logic [1:0] ST_HALF     = 2'b01;
    localparam logic [1:0] ST_OUT      = 2'b10;
    localparam logic [1:0] ST_OUT_HALF = 2'b11;

endpackage : one_to_two_pkg
`default_nettype wire

// File: rtl/one_to_two_if.sv
`default_nettype none
// ============================================================================
//  Module      : one_to_two_if
//  Description : Stream bundle for the one_to_two converter: a word-wide
//                ready/valid input and a pair-wide ready/valid output.
//                master : producer of din / consumer of dout (environment)
//                slave  : the converter itself
//  Macro       : ONE_TO_TWO_FLUSH_EN adds din_last and dout_half.
//  Revision    : 1.0 - initial release
// ============================================================================
interface one_to_two_if #(
    parameter int unsigned WORD_LEN = 33
);
    logic [WORD_LEN-1:0]   din;
    logic                  din_valid;
    logic                  din_ready;
    logic [2*WORD_LEN-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
`ifdef ONE_TO_TWO_FLUSH_EN
    logic                  din_last;
    logic                  dout_half;
`endif

`ifdef ONE_TO_TWO_FLUSH_EN
    modport master (
        output din, din_valid, din_last, dout_ready,
        input  din_ready, dout, dout_valid, dout_half
    );
    modport slave (
        input  din, din_valid, din_last, dout_ready,
        output din_ready, dout, dout_valid, dout_half
    );
`else
    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid
    );
    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid
    );
`endif

endinterface : one_to_two_if
`default_nettype wire

// File: rtl/one_to_two_out_stage.sv
`default_nettype none
// ============================================================================
//  Module      : one_to_two_out_stage
//  Description : Output pair register of the one_to_two converter. Loads a
//                complete pair on i_load, holds it until consumed, and tells
//                the front end whether the slot can take a pair this cycle.
//  Ports       : clk, rst_n       - clock, synchronous active-low reset
//                i_load           - load i_load_data into the pair register
//                i_load_data      - pair to load, {upper, lower}
//                i_load_half      - (flush build) loaded pair is half-padded
//                i_dout_ready     - downstream consumes the held pair
//                o_dout           - registered pair
//                o_dout_valid     - o_dout holds a pair
//                o_dout_half      - (flush build) upper half is padding
//                o_out_free       - slot empty or emptying this cycle
//  Macro       : ONE_TO_TWO_FLUSH_EN adds the half-pair flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module one_to_two_out_stage
    import one_to_two_pkg::*;
#(
    parameter int unsigned WORD_LEN = DEFAULT_WORD_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [2*WORD_LEN-1:0] i_load_data,
`ifdef ONE_TO_TWO_FLUSH_EN
    input  logic                  i_load_half,
    output logic                  o_dout_half,
`endif
    input  logic                  i_dout_ready,
    output logic [2*WORD_LEN-1:0] o_dout,
    output logic                  o_dout_valid,
    output logic                  o_out_free
);

    logic [2*WORD_LEN-1:0] r_dout;
    logic                  r_dout_valid;
`ifdef ONE_TO_TWO_FLUSH_EN
    logic                  r_dout_half;
`endif

    // A load always wins over a drain: when both happen on one edge the old
    // pair leaves and the new one takes its place, so valid stays high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
`ifdef ONE_TO_TWO_FLUSH_EN
            r_dout_half  <= 1'b0;
`endif
        end else if (i_load) begin
            r_dout       <= i_load_data;
            r_dout_valid <= 1'b1;
`ifdef ONE_TO_TWO_FLUSH_EN
            r_dout_half  <= i_load_half;
`endif
        end else if (i_dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_out_free   = !r_dout_valid || i_dout_ready;
`ifdef ONE_TO_TWO_FLUSH_EN
    assign o_dout_half  = r_dout_half;
`endif

endmodule : one_to_two_out_stage
`default_nettype wire

// File: rtl/one_to_two.sv
`default_nettype none
// ============================================================================
//  Module      : one_to_two
//  Description : Width up-converter. Accepts WORD_LEN words on a ready/valid
//                stream and emits them as 2*WORD_LEN pairs, first word in the
//                lower half. One word per cycle in, one pair per two cycles
//                out when the output is never stalled.
//  Ports       : clk    - rising-edge clock
//                rst_n  - synchronous active-low reset
//                bus    - one_to_two_if.slave: din/din_valid/din_ready,
//                         dout/dout_valid/dout_ready (+ din_last/dout_half)
//  Macro       : ONE_TO_TWO_FLUSH_EN - a word marked din_last that lands in
//                the lower slot is emitted alone with a zero upper half.
//  Revision    : 1.0 - initial release
// ============================================================================
module one_to_two
    import one_to_two_pkg::*;
#(
    parameter int unsigned WORD_LEN = DEFAULT_WORD_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    one_to_two_if.slave bus
);

    // Lower-half holding slot.
    logic [WORD_LEN-1:0]   r_lo;
    logic                  r_lo_valid;
`ifdef ONE_TO_TWO_FLUSH_EN
    logic                  r_lo_last;
    logic                  w_flush;
`endif

    logic                  w_out_free;
    logic                  w_dout_valid;
    logic [1:0]            w_state;
    logic                  w_din_ready;
    logic                  w_accept;
    logic                  w_load_pair;
    logic                  w_load;
    logic [2*WORD_LEN-1:0] w_load_data;
    logic                  w_lo_blocked;

    // din_ready depends only on registered flags and dout_ready, never on
    // din_valid, so there is no combinational loop through the producer.
    always_comb begin
        w_state     = {w_dout_valid, r_lo_valid};
        w_din_ready = 1'b0;
`ifdef ONE_TO_TWO_FLUSH_EN
        // A held last word must leave alone before anything else enters.
        w_lo_blocked = r_lo_last;
`else
        w_lo_blocked = 1'b0;
`endif
        case (w_state)
            ST_EMPTY:    w_din_ready = 1'b1;
            ST_OUT:      w_din_ready = 1'b1;
            ST_HALF:     w_din_ready = !w_lo_blocked;
            ST_OUT_HALF: w_din_ready = bus.dout_ready && !w_lo_blocked;
            default:     w_din_ready = 1'b0;
        endcase
    end

    assign w_accept    = bus.din_valid && w_din_ready;
    // Second word of a pair: only reachable when the out slot is free.
    assign w_load_pair = w_accept && r_lo_valid;

`ifdef ONE_TO_TWO_FLUSH_EN
    assign w_flush     = r_lo_valid && r_lo_last && w_out_free;
    assign w_load      = w_load_pair || w_flush;
    assign w_load_data = w_flush ? {{WORD_LEN{1'b0}}, r_lo} : {bus.din, r_lo};
`else
    assign w_load      = w_load_pair;
    assign w_load_data = {bus.din, r_lo};
`endif

    // lo keeps its contents when it empties; only the flag is cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lo       <= '0;
            r_lo_valid <= 1'b0;
`ifdef ONE_TO_TWO_FLUSH_EN
            r_lo_last  <= 1'b0;
`endif
        end else if (w_accept && !r_lo_valid) begin
            r_lo       <= bus.din;
            r_lo_valid <= 1'b1;
`ifdef ONE_TO_TWO_FLUSH_EN
            r_lo_last  <= bus.din_last;
`endif
        end else if (w_load) begin
            r_lo_valid <= 1'b0;
`ifdef ONE_TO_TWO_FLUSH_EN
            r_lo_last  <= 1'b0;
`endif
        end
    end

    one_to_two_out_stage #(
        .WORD_LEN     (WORD_LEN)
    ) u_out_stage (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_load_data  (w_load_data),
`ifdef ONE_TO_TWO_FLUSH_EN
        .i_load_half  (w_flush),
        .o_dout_half  (bus.dout_half),
`endif
        .i_dout_ready (bus.dout_ready),
        .o_dout       (bus.dout),
        .o_dout_valid (w_dout_valid),
        .o_out_free   (w_out_free)
    );

    assign bus.dout_valid = w_dout_valid;
    assign bus.din_ready  = w_din_ready;

endmodule : one_to_two
`default_nettype wire

// File: tb/tb_one_to_two.sv
`default_nettype none
// ============================================================================
//  Module      : tb_one_to_two
//  Description : Directed self-checking bench for one_to_two: reset,
//                streaming, back-pressure, simultaneous drain/load, a long
//                randomised handshake run and (flush build) the half pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_one_to_two;
    import one_to_two_pkg::*;

    localparam int unsigned W = DEFAULT_WORD_LEN;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [3:0] seen;

    one_to_two_if #(.WORD_LEN(W)) bus ();

    one_to_two #(.WORD_LEN(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Occupancy states visited while out of reset.
    always @(posedge clk) begin
        if (rst_n) seen[dut.w_state] <= 1'b1;
    end

    function automatic logic [2*W-1:0] pair(input int unsigned first, input int unsigned second);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = W'(first);
        b = W'(second);
        return {b, a};
    endfunction

    task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned next_in;
        int unsigned n;
        int          cyc;

        checks = 0;
        errors = 0;
        seen   = 4'h0;

        // ---------------- reset with traffic presented -------------------
        rst_n          = 1'b0;
        bus.din        = W'(99);
        bus.din_valid  = 1'b1;
        bus.dout_ready = 1'b1;
`ifdef ONE_TO_TWO_FLUSH_EN
        bus.din_last   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        #1;
        chk("rst_dout_valid", 132'(bus.dout_valid), 1'b0);
        chk("rst_dout", bus.dout, '0);
        chk("rst_din_ready", 132'(bus.din_ready), 1'b1);
        tick();
        chk("rst_no_pair", 132'(bus.dout_valid), 1'b0);

        // ---------------- streaming 1..4, dout_ready high ----------------
        bus.dout_ready = 1'b1;
        bus.din_valid  = 1'b1;
        bus.din        = W'(1);
        #1 chk("str_rdy1", 132'(bus.din_ready), 1'b1);
        tick();
        chk("str_no_pair_yet", 132'(bus.dout_valid), 1'b0);
        bus.din = W'(2);
        #1 chk("str_rdy2", 132'(bus.din_ready), 1'b1);
        tick();
        chk("str_pair12_valid", 132'(bus.dout_valid), 1'b1);
        chk("str_pair12", bus.dout, pair(1, 2));
        bus.din = W'(3);
        #1 chk("str_rdy3", 132'(bus.din_ready), 1'b1);
        tick();
        chk("str_gap_valid", 132'(bus.dout_valid), 1'b0);
        bus.din = W'(4);
        #1 chk("str_rdy4", 132'(bus.din_ready), 1'b1);
        tick();
        chk("str_pair34_valid", 132'(bus.dout_valid), 1'b1);
        chk("str_pair34", bus.dout, pair(3, 4));
        bus.din_valid = 1'b0;
        tick();
        chk("str_drained", 132'(bus.dout_valid), 1'b0);

        // ---------------- back-pressure 5,6,7 then 8 -------------------
        bus.dout_ready = 1'b0;
        bus.din_valid  = 1'b1;
        bus.din        = W'(5);
        tick();
        bus.din = W'(6);
        tick();
        chk("bp_pair56", bus.dout, pair(5, 6));
        bus.din = W'(7);
        #1 chk("bp_rdy_out", 132'(bus.din_ready), 1'b1);
        tick();
        bus.din = W'(8);
        #1 chk("bp_rdy_low", 132'(bus.din_ready), 1'b0);
        tick();
        chk("bp_pair56_held", bus.dout, pair(5, 6));
        chk("bp_valid_held", 132'(bus.dout_valid), 1'b1);
        #1 chk("bp_rdy_still_low", 132'(bus.din_ready), 1'b0);
        bus.dout_ready = 1'b1;
        #1 chk("bp_rdy_release", 132'(bus.din_ready), 1'b1);
        tick();
        chk("bp_pair78_valid", 132'(bus.dout_valid), 1'b1);
        chk("bp_pair78", bus.dout, pair(7, 8));
        bus.din_valid = 1'b0;
        tick();
        chk("bp_drained", 132'(bus.dout_valid), 1'b0);

        // ---------------- simultaneous drain and load --------------------
        bus.dout_ready = 1'b0;
        bus.din_valid  = 1'b1;
        bus.din        = W'(20);
        tick();
        bus.din = W'(21);
        tick();
        bus.din = W'(22);
        tick();
        chk("sim_pair_held", bus.dout, pair(20, 21));
        bus.din        = W'(23);
        bus.dout_ready = 1'b1;
        tick();
        chk("sim_valid_stays", 132'(bus.dout_valid), 1'b1);
        chk("sim_new_pair", bus.dout, pair(22, 23));
        bus.din_valid = 1'b0;
        tick();
        chk("sim_drained", 132'(bus.dout_valid), 1'b0);
        bus.dout_ready = 1'b0;

        // ---------------- random handshakes over 10000 words -------------
        next_in = 0;
        n       = 0;
        cyc     = 0;
        while (n < 5000 && cyc < 60000) begin
            bus.din_valid  = (next_in < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.dout_ready = 1'($urandom_range(0, 1));
            bus.din        = W'(next_in);
            #2;
            if (bus.dout_valid && bus.dout_ready) begin
                chk("rand_pair", bus.dout, pair(2 * n, 2 * n + 1));
                n++;
            end
            if (bus.din_valid && bus.din_ready) next_in++;
            tick();
            cyc++;
        end
        chk("rand_pair_count", 132'(n), 132'(5000));
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        tick();
        chk("rand_idle", 132'(bus.dout_valid), 1'b0);

`ifdef ONE_TO_TWO_FLUSH_EN
        // ---------------- flush of a trailing single word ----------------
        bus.dout_ready = 1'b1;
        bus.din_valid  = 1'b1;
        bus.din_last   = 1'b1;
        bus.din        = W'(9);
        tick();
        bus.din_valid  = 1'b0;
        bus.din_last   = 1'b0;
        #1 chk("fl_rdy_low", 132'(bus.din_ready), 1'b0);
        chk("fl_not_yet", 132'(bus.dout_valid), 1'b0);
        tick();
        chk("fl_valid", 132'(bus.dout_valid), 1'b1);
        chk("fl_dout", bus.dout, pair(9, 0));
        chk("fl_half", 132'(bus.dout_half), 1'b1);
        #1 chk("fl_rdy_back", 132'(bus.din_ready), 1'b1);
        bus.din_valid = 1'b1;
        bus.din       = W'(10);
        tick();
        bus.din = W'(11);
        tick();
        chk("fl_pair_10_11", bus.dout, pair(10, 11));
        chk("fl_full_half", 132'(bus.dout_half), 1'b0);
        bus.din_valid = 1'b0;
        tick();
`endif

        chk("state_coverage", 132'(seen), 132'(4'hF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_one_to_two
`default_nettype wire

// File: doc/one_to_two.md
# one_to_two

Width up-converter: accepts single WORD_LEN words on a ready/valid stream and emits them packed as 2*WORD_LEN pairs. The first word accepted goes in the less significant half. It is the receive-side counterpart of the pair-to-word serializer on the communication links, restoring the original pair layout. It sustains one input word per cycle and one output pair every two cycles under no back-pressure.

## Interface
- WORD_LEN, 33, width of one input word
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- din  in  WORD_LEN  input word
- din_valid  in  1  din holds a word
- din_ready  out  1  word accepted on cycle with din_valid & din_ready
- din_last  in  1  (ONE_TO_TWO_FLUSH_EN only) current word ends a packet
- dout  out  2*WORD_LEN  {second word, first word}
- dout_valid  out  1  dout holds a pair
- dout_ready  in  1  pair consumed on cycle with dout_valid & dout_ready
- dout_half  out  1  (ONE_TO_TWO_FLUSH_EN only) upper half is zero padding

## Operation
- Two registered slots:
  - lo: one word, flag lo_valid, plus lo_last with the macro.
  - out: pair register, flag dout_valid.
- States:
  - EMPTY: !lo_valid, !dout_valid.
  - HALF: lo_valid, !dout_valid.
  - OUT: !lo_valid, dout_valid.
  - OUT_HALF: lo_valid, dout_valid.
- out_free = !dout_valid | dout_ready.
- din_ready = !lo_valid | out_free. With the macro, din_ready is additionally 0 while lo_last = 1.
- Accept with !lo_valid:
  - lo <= din, lo_valid <= 1.
  - If out_free and dout_valid, the pair drains: dout_valid <= 0.
- Accept with lo_valid (out_free guaranteed):
  - out <= {din, lo}, dout_valid <= 1, lo_valid <= 0.
- No accept:
  - If dout_ready & dout_valid, then dout_valid <= 0.
  - lo is unchanged.
- dout is driven only from the out register. It is never combinational from din.
- Pair halves are never split or reordered. Word n of a stream always lands in half (n mod 2).
- When dout_valid = 0, dout holds its last value. Consumers must not sample it.

## Timing
- Reset, on a rising clk edge with rst_n = 0:
  - lo_valid = 0, dout_valid = 0, dout = 0, lo = 0.
  - dout_half = 0 and lo_last = 0.
  - The first cycle after reset has din_ready = 1.
  - Any word or pair in flight at reset is discarded; there is no partial-pair recovery.
  - While rst_n = 0, din_valid and dout_ready are ignored.
- Latency: the second word of a pair is accepted at edge k; dout_valid = 1 from cycle k+1.
- Throughput:
  - With dout_ready held high: din_ready stays 1 continuously, and dout_valid pulses every second cycle.
  - Back-pressure: in OUT_HALF with dout_ready = 0, din_ready = 0. There is no combinational loop from din_valid to din_ready.
- Simultaneous events: in OUT_HALF with dout_ready = 1 and din_valid = 1:
  - The pair drains and the new pair loads on the same edge.
  - dout_valid stays 1.
- dout_ready may be high with dout_valid = 0; this has no effect.

## Configuration
- ONE_TO_TWO_FLUSH_EN defined: adds din_last and dout_half.
  - Last word accepted into an empty lo:
    - lo_last <= 1 and din_ready drops.
    - On the next edge with out_free: out <= {0, lo}, dout_half <= 1, lo_valid <= 0, lo_last <= 0.
  - Last word arriving as the second word: a normal pair is emitted with dout_half = 0.
  - dout_half is registered with out and cleared whenever a full pair loads.
- ONE_TO_TWO_FLUSH_EN undefined:
  - The din_last and dout_half ports do not exist.
  - A trailing odd word remains in lo until another word arrives.

## Structure
- Package one_to_two_pkg:
  - the WORD_LEN default;
  - the state encoding localparams (ST_EMPTY, ST_HALF, ST_OUT, ST_OUT_HALF), used by the bench for state coverage.
- One sub-module, one_to_two_out_stage. It holds:
  - the pair register, dout_valid and dout_half;
  - load/drain control with an out_free output.
- The top holds lo, its flags and din_ready.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with din_valid = 1, then release.
  - Expect dout_valid = 0, dout = 0, din_ready = 1.
  - Expect no pair from words presented during reset.
- Streaming: din = 1, 2, 3, 4 on consecutive cycles, with dout_ready = 1.
  - Expect dout = {2, 1} one cycle after word 2, then {4, 3}.
  - Expect din_ready = 1 throughout.
- Back-pressure: feed 5, 6, 7 with dout_ready = 0.
  - Expect the pair {6, 5} held.
  - Expect din_ready = 0 after 7 is accepted.
  - Raise dout_ready: {6, 5} drains, and the pair holding 7 forms with the next word, 8.
- Simultaneous drain and load: in OUT_HALF, assert dout_ready and din_valid together.
  - Expect dout_valid to stay 1 and dout to change to the new pair on the same edge.
- Random: random din_valid/dout_ready (50%) over 10k words of an incrementing sequence.
  - Expect output pairs {2n+1, 2n} in order, with no loss or duplication.
- Flush (macro on): word 9 with din_last = 1 into an empty lo.
  - Expect dout = {0, 9} with dout_half = 1.
  - Expect din_ready = 0 until it loads.
  - The following pair {11, 10} has dout_half = 0.
